// File: rtl/st7735_spi_sink.sv
// Panel-side ST7735 4-wire SPI receiver: decodes CASET/RASET/RAMWR into (x, y, RGB565) pixel writes.
// Define ST7735_SINK_MADCTL_EN to honour MADCTL (0x36) MX/MY mirroring of reported coordinates.
module st7735_spi_sink #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 79
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        oled_cs,
  input  logic        oled_clk,
  input  logic        oled_mosi,
  input  logic        oled_dc,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        frame_done
);

  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_RASET,
    S_RAMWR,
    S_SKIP
`ifdef ST7735_SINK_MADCTL_EN
    , S_MADCTL
`endif
  } state_t;

  logic [1:0] cs_sync, sclk_sync, mosi_sync, dc_sync;
  logic       sclk_d;
  logic       sclk_rise;

  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  state_t     state;
  logic [1:0] param_idx;
  logic [7:0] xs, xe, x;
  logic [6:0] ys, ye, y;
  logic       hi_flag;
  logic [7:0] hi_byte;

  logic       x_wrap, y_wrap, visible;
  logic [7:0] rep_x;
  logic [6:0] rep_y;

`ifdef ST7735_SINK_MADCTL_EN
  logic mx, my;
`endif

  // CS synchroniser resets high so the link starts deselected
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      dc_sync   <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], oled_cs};
      sclk_sync <= {sclk_sync[0], oled_clk};
      mosi_sync <= {mosi_sync[0], oled_mosi};
      dc_sync   <= {dc_sync[0], oled_dc};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'd0;
      rx_dc      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shreg, mosi_sync[1]};
          rx_dc      <= dc_sync[1];
        end
      end
    end
  end

  always_comb begin
    x_wrap  = (x == xe) || (x == XM);
    y_wrap  = (y == ye) || (y == YM);
    visible = (x <= XM) && (y <= YM);
`ifdef ST7735_SINK_MADCTL_EN
    rep_x = mx ? (XM - x) : x;
    rep_y = my ? (YM - y) : y;
`else
    rep_x = x;
    rep_y = y;
`endif
  end

  // Command bytes always win; data bytes are interpreted by the current state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      param_idx  <= 2'd0;
      xs         <= 8'd0;
      xe         <= XM;
      ys         <= 7'd0;
      ye         <= YM;
      x          <= 8'd0;
      y          <= 7'd0;
      hi_flag    <= 1'b0;
      hi_byte    <= 8'd0;
      pix_valid  <= 1'b0;
      pix_x      <= 8'd0;
      pix_y      <= 7'd0;
      pix_color  <= 16'd0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 8'd0;
      frame_done <= 1'b0;
`ifdef ST7735_SINK_MADCTL_EN
      mx         <= 1'b0;
      my         <= 1'b0;
`endif
    end else begin
      pix_valid  <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        if (!rx_dc) begin
          cmd_valid <= 1'b1;
          cmd_code  <= rx_byte;
          hi_flag   <= 1'b0;
          param_idx <= 2'd0;
          case (rx_byte)
            8'h2A: state <= S_CASET;
            8'h2B: state <= S_RASET;
            8'h2C: begin
              state <= S_RAMWR;
              x     <= xs;
              y     <= ys;
            end
            8'h01: begin
              state <= S_IDLE;
              xs    <= 8'd0;
              xe    <= XM;
              ys    <= 7'd0;
              ye    <= YM;
            end
`ifdef ST7735_SINK_MADCTL_EN
            8'h36: state <= S_MADCTL;
`endif
            default: state <= S_SKIP;
          endcase
        end else begin
          case (state)
            S_CASET: begin
              if (param_idx == 2'd1) xs <= rx_byte;
              if (param_idx == 2'd3) begin
                xe    <= rx_byte;
                state <= S_SKIP;
              end
              param_idx <= param_idx + 2'd1;
            end
            S_RASET: begin
              if (param_idx == 2'd1) ys <= rx_byte[6:0];
              if (param_idx == 2'd3) begin
                ye    <= rx_byte[6:0];
                state <= S_SKIP;
              end
              param_idx <= param_idx + 2'd1;
            end
            S_RAMWR: begin
              if (!hi_flag) begin
                hi_byte <= rx_byte;
                hi_flag <= 1'b1;
              end else begin
                hi_flag <= 1'b0;
                if (visible) begin
                  pix_valid  <= 1'b1;
                  pix_x      <= rep_x;
                  pix_y      <= rep_y;
                  pix_color  <= {hi_byte, rx_byte};
                  frame_done <= (x == xe) && (y == ye);
                end
                // Wrapping at X_MAX/Y_MAX as well keeps XS > XE windows bounded
                if (x_wrap) begin
                  x <= xs;
                  y <= y_wrap ? ys : (y + 7'd1);
                end else begin
                  x <= x + 8'd1;
                end
              end
            end
`ifdef ST7735_SINK_MADCTL_EN
            S_MADCTL: begin
              my    <= rx_byte[7];
              mx    <= rx_byte[6];
              state <= S_SKIP;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_st7735_spi_sink.sv
// Directed self-checking bench for st7735_spi_sink: bit-bangs SPI bytes and checks decoded pixels/commands.
module tb_st7735_spi_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        oled_cs, oled_clk, oled_mosi, oled_dc;
  logic        pix_valid, cmd_valid, frame_done;
  logic [7:0]  pix_x, cmd_code;
  logic [6:0]  pix_y;
  logic [15:0] pix_color;

  int checks = 0;
  int passes = 0;
  int cycCnt = 0;
  int lastRise = 0;
  int lastPixCyc = 0;
  bit perByteCs = 1'b0;

  logic [31:0] pixQ[$];
  int          pixCyc[$];
  logic [7:0]  cmdQ[$];

  st7735_spi_sink dut (
    .clk(clk), .resetn(resetn),
    .oled_cs(oled_cs), .oled_clk(oled_clk), .oled_mosi(oled_mosi), .oled_dc(oled_dc),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Capture every output pulse so a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (pix_valid) begin
      pixQ.push_back({frame_done, pix_x, pix_y, pix_color});
      pixCyc.push_back(cycCnt);
    end
    if (cmd_valid) cmdQ.push_back(cmd_code);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic dc, input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      oled_dc   = dc;
      oled_mosi = b[7-i];
      oled_clk  = 1'b0;
      waitClk(4);
      oled_clk  = 1'b1;
      lastRise  = cycCnt;
      waitClk(4);
    end
    oled_clk = 1'b0;
    waitClk(2);
  endtask

  task automatic sendByte(input logic dc, input logic [7:0] b);
    if (perByteCs) begin
      oled_cs = 1'b0;
      waitClk(3);
    end
    applyStimulus(dc, b, 8);
    if (perByteCs) begin
      oled_cs = 1'b1;
      waitClk(3);
    end
  endtask

  task automatic sendCmd(input logic [7:0] b);
    sendByte(1'b0, b);
  endtask

  task automatic sendData(input logic [7:0] b);
    sendByte(1'b1, b);
  endtask

  task automatic sendPixel(input logic [15:0] c);
    sendData(c[15:8]);
    sendData(c[7:0]);
  endtask

  task automatic sendWindow(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] y0, input logic [7:0] y1);
    sendCmd(8'h2A);
    sendData(8'h00); sendData(x0); sendData(8'h00); sendData(x1);
    sendCmd(8'h2B);
    sendData(8'h00); sendData(y0); sendData(8'h00); sendData(y1);
  endtask

  task automatic expectPixel(input logic [7:0] ex, input logic [6:0] ey,
                             input logic [15:0] ec, input logic efd);
    logic [31:0] e;
    waitClk(4);
    if (pixQ.size() == 0) begin
      checkOutput("pixPresent", 32'd0, 32'd1);
    end else begin
      e = pixQ.pop_front();
      lastPixCyc = pixCyc.pop_front();
      checkOutput("pixX", {24'd0, e[30:23]}, {24'd0, ex});
      checkOutput("pixY", {25'd0, e[22:16]}, {25'd0, ey});
      checkOutput("pixColor", {16'd0, e[15:0]}, {16'd0, ec});
      checkOutput("frameDone", {31'd0, e[31]}, {31'd0, efd});
    end
  endtask

  task automatic expectNoPixel();
    waitClk(4);
    checkOutput("pixCount", pixQ.size(), 32'd0);
  endtask

  task automatic expectCmd(input logic [7:0] code);
    waitClk(4);
    if (cmdQ.size() == 0) checkOutput("cmdPresent", 32'd0, 32'd1);
    else checkOutput("cmdCode", {24'd0, cmdQ.pop_front()}, {24'd0, code});
  endtask

  task automatic windowRun();
    sendWindow(8'h02, 8'h03, 8'h05, 8'h06);
    sendCmd(8'h2C);
    for (int k = 1; k <= 5; k++) sendPixel(16'(k * 16'h1111));
    expectCmd(8'h2A);
    expectCmd(8'h2B);
    expectCmd(8'h2C);
    expectPixel(8'd2, 7'd5, 16'h1111, 1'b0);
    expectPixel(8'd3, 7'd5, 16'h2222, 1'b0);
    expectPixel(8'd2, 7'd6, 16'h3333, 1'b0);
    expectPixel(8'd3, 7'd6, 16'h4444, 1'b1);
    expectPixel(8'd2, 7'd5, 16'h5555, 1'b0);
    expectNoPixel();
  endtask

  initial begin
    resetn = 1'b0; oled_cs = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0; oled_dc = 1'b0;
    waitClk(3);
    checkOutput("rstPixValid", {31'd0, pix_valid}, 32'd0);
    checkOutput("rstCmdValid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("rstFrameDone", {31'd0, frame_done}, 32'd0);
    checkOutput("rstOutputs", {1'b0, pix_x, pix_y, pix_color}, 32'd0);
    checkOutput("rstCmdCode", {24'd0, cmd_code}, 32'd0);
    resetn = 1'b1;
    waitClk(3);
    oled_cs = 1'b0;
    waitClk(3);

    // Default window after reset and fixed latency
    sendCmd(8'h2C);
    sendPixel(16'hF800);
    expectCmd(8'h2C);
    expectPixel(8'd0, 7'd0, 16'hF800, 1'b0);
    checkOutput("latency", lastPixCyc - lastRise, 32'd4);
    checkOutput("colorHold", {16'd0, pix_color}, 32'h0000_F800);

    windowRun();
    oled_cs = 1'b1;
    perByteCs = 1'b1;
    waitClk(3);
    windowRun();
    perByteCs = 1'b0;
    oled_cs = 1'b0;
    waitClk(3);

    // Partial byte aborted by CS is discarded
    sendCmd(8'h2C);
    applyStimulus(1'b1, 8'hFF, 5);
    oled_cs = 1'b1;
    waitClk(4);
    oled_cs = 1'b0;
    waitClk(3);
    sendPixel(16'h1234);
    expectCmd(8'h2C);
    expectPixel(8'd2, 7'd5, 16'h1234, 1'b0);

    // Command between pixel bytes drops the held high byte
    sendCmd(8'h2C);
    sendData(8'h77);
    sendCmd(8'h2C);
    sendPixel(16'hABCD);
    expectCmd(8'h2C);
    expectCmd(8'h2C);
    expectPixel(8'd2, 7'd5, 16'hABCD, 1'b0);

    // SWRESET window restore and unknown command
    sendCmd(8'h01);
    sendCmd(8'h3A);
    sendData(8'h05);
    expectCmd(8'h01);
    expectCmd(8'h3A);
    expectNoPixel();
    sendCmd(8'h2C);
    sendPixel(16'hAABB);
    expectCmd(8'h2C);
    expectPixel(8'd0, 7'd0, 16'hAABB, 1'b0);

    // Columns beyond X_MAX advance silently
    sendWindow(8'hA0, 8'hA5, 8'h00, 8'h4F);
    sendCmd(8'h2C);
    for (int k = 0; k < 6; k++) sendPixel(16'h0F0F);
    expectNoPixel();

    // Wrap at X_MAX even though XE is further right
    sendWindow(8'h9E, 8'hA0, 8'h00, 8'h4F);
    sendCmd(8'h2C);
    for (int k = 0; k < 3; k++) sendPixel(16'(16'h0100 + k));
    expectPixel(8'd158, 7'd0, 16'h0100, 1'b0);
    expectPixel(8'd159, 7'd0, 16'h0101, 1'b0);
    expectPixel(8'd158, 7'd1, 16'h0102, 1'b0);

    // Wrap at Y_MAX even though YE is further down
    sendWindow(8'h00, 8'h00, 8'h4E, 8'h55);
    sendCmd(8'h2C);
    for (int k = 0; k < 3; k++) sendPixel(16'(16'h0200 + k));
    expectPixel(8'd0, 7'd78, 16'h0200, 1'b0);
    expectPixel(8'd0, 7'd79, 16'h0201, 1'b0);
    expectPixel(8'd0, 7'd78, 16'h0202, 1'b0);
    cmdQ.delete();

    // Reset mid-byte restores the default window
    applyStimulus(1'b0, 8'h2A, 5);
    resetn = 1'b0;
    waitClk(2);
    checkOutput("midRstCmdCode", {24'd0, cmd_code}, 32'd0);
    resetn = 1'b1;
    waitClk(3);
    sendCmd(8'h2C);
    sendPixel(16'h1234);
    expectCmd(8'h2C);
    expectPixel(8'd0, 7'd0, 16'h1234, 1'b0);

    // MADCTL mirroring, or plain unknown-command handling without it
    sendCmd(8'h36);
    sendData(8'h40);
    sendCmd(8'h2C);
    sendPixel(16'h5A5A);
    expectCmd(8'h36);
    expectCmd(8'h2C);
`ifdef ST7735_SINK_MADCTL_EN
    expectPixel(8'd159, 7'd0, 16'h5A5A, 1'b0);
`else
    expectPixel(8'd0, 7'd0, 16'h5A5A, 1'b0);
`endif
    expectNoPixel();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/st7735_spi_sink.md
# st7735_spi_sink

Panel-side receiver for the ST7735 4-wire SPI link: it samples the `oled_cs`/`oled_clk`/`oled_mosi`/`oled_dc` lines that the LCD driver produces and decodes CASET/RASET/RAMWR traffic into a stream of (x, y, RGB565) pixel writes. It sits in simulation benches and on-board loopback builds as the responder to the driver. Its output feeds a framebuffer model or checker, which closes the loop on pattern generators such as the checkered top.

## Interface
Parameters:
- `X_MAX`, 159: last visible column; reset value of XE.
- `Y_MAX`, 79: last visible row; reset value of YE.

Ports:
- `clk` in 1: system clock; must be ≥ 4× SCLK frequency.
- `resetn` in 1: asynchronous, active-low reset.
- `oled_cs` in 1: chip select, active low.
- `oled_clk` in 1: SPI clock; mode 0, data sampled on rising edge.
- `oled_mosi` in 1: serial data, MSB first.
- `oled_dc` in 1: 0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
- `pix_valid` out 1: one-cycle pulse per decoded visible pixel.
- `pix_x` out 8: column of the pixel.
- `pix_y` out 7: row of the pixel.
- `pix_color` out 16: RGB565 value, first byte received in [15:8].
- `cmd_valid` out 1: one-cycle pulse per command byte.
- `cmd_code` out 8: last command byte.
- `frame_done` out 1: one-cycle pulse when the pixel at (XE, YE) is written.

## Operation
- **Input synchronisation.** All four SPI inputs pass through 2-flop synchronisers. A rising-edge detector runs on synced SCLK.
- **Bit assembly.** Synced CS high forces the bit counter to 0 and discards any partial byte. No other state is cleared.
- On each SCLK rise with CS low, MOSI is shifted in. On the 8th bit, the byte and the DC value are latched.
- **Decoder FSM** states: IDLE, CASET, RASET, RAMWR, SKIP. A command byte (DC=0) is accepted from any state, pulses `cmd_valid`, and then:
  - 0x2A → CASET, parameter index 0.
  - 0x2B → RASET, parameter index 0.
  - 0x2C → RAMWR; x←XS, y←YS, high-byte flag cleared.
  - 0x01 (SWRESET) → window restored to XS=0, XE=X_MAX, YS=0, YE=Y_MAX; state IDLE.
  - Any other code → SKIP. Data bytes are ignored until the next command.
- **CASET/RASET** take 4 parameter bytes: start hi, start lo, end hi, end lo.
  - Hi bytes are ignored. The lo byte is truncated to 8 bits (X) or 7 bits (Y).
  - After the 4th byte the state becomes SKIP.
- **RAMWR** data bytes pair up into pixels: the first byte is held, and the second completes `pix_color`.
- **Pixel advance** after each completed pixel, using the current (x, y):
  - If x == XE or x == X_MAX: x←XS, and y advances under the same rule (y == YE or y == Y_MAX → y←YS, else y+1).
  - Otherwise x←x+1.
  - This rule also bounds runaway counting when XS > XE.
- **Visibility.** A pixel with x > X_MAX or y > Y_MAX advances the counters but produces no `pix_valid`.
- **`frame_done`** pulses in the same cycle as `pix_valid` for the pixel at (XE, YE).
- **Reset values.** All outputs are 0; FSM is IDLE; window is (0, X_MAX, 0, Y_MAX); x = y = 0.

## Timing
- The 8th SCLK rise becomes visible on synced SCLK 2 clk edges after the line goes high. The edge is detected on the 3rd edge. `pix_valid`/`cmd_valid` are asserted, registered, on the 4th edge.
- Fixed latency: 4 clk cycles. Outputs are stable for exactly 1 cycle. There is no back-pressure.
- `pix_x`, `pix_y`, `pix_color` and `cmd_code` hold their values until the next pulse.
- **CS toggled between bytes** (per-byte CS) is legal. The RAMWR high-byte flag and FSM state persist across CS high.
- **`resetn` low mid-byte or mid-pixel** clears everything asynchronously. The next byte is decoded from bit 7.
- **Command byte between pixel bytes** discards the held high byte.

## Configuration
- `ST7735_SINK_MADCTL_EN` defined:
  - Command 0x36 latches bit 7 (MY) and bit 6 (MX) of its single parameter byte. Both are reset to 0.
  - Reported `pix_x` = X_MAX − x when MX=1; reported `pix_y` = Y_MAX − y when MY=1.
  - Visibility and `frame_done` use the internal, unmirrored x/y.
- Not defined: 0x36 is treated as an unknown command (SKIP) and there is no mirroring.

## Test plan
- **Reset defaults.** After reset, send 0x2C and then 0xF8,0x00 → `pix_valid` with x=0, y=0, color=0xF800, 4 clks after the last SCLK rise.
- **Window wrap.** CASET 00,02,00,03; RASET 00,05,00,06; RAMWR with 4 pixels → (2,5),(3,5),(2,6),(3,6). `frame_done` fires with the 4th pixel; a 5th pixel lands at (2,5).
- **Per-byte CS and abort.** Toggle CS between every byte → identical results. Raise CS after 5 bits of a data byte, then send a full byte → the partial byte is discarded and the full byte is decoded correctly.
- **Unknown command.** Send 0x3A followed by data 0x05 → `cmd_valid` with code 0x3A and no `pix_valid`. A following 0x2C, AA, BB → a pixel with color 0xAABB.
- **Invisible pixel.** CASET end = 0xA5 with start 0xA0 → no `pix_valid` for x=160…165.
- **Mirroring** (`ST7735_SINK_MADCTL_EN`). 0x36 with param 0x40, then RAMWR of 1 pixel at (0,0) → `pix_x`=159, `pix_y`=0.
